host_dma_chunker: RTL and testbench
===================================

Name: host_dma_chunker

Overview:
- Sits directly downstream of the per-direction host DMA arbiter and upstream of the XDMA host channel (one instance per direction).
- Splits each arbitrated host DMA request into chunks that never cross a CHUNK_SIZE-aligned boundary.
- Tracks per-chunk completions from XDMA and emits exactly one done per original request, in order.

Parameters:
- ADDR_BITS, 64, physical address width.
- LEN_BITS, 28, request length width in bytes.
- CHUNK_LOG, 12, log2 of chunk size (4 KB).
- PID_BITS, 6, request tag (pid) width; carried through unmodified.
- N_OUTSTANDING, 16, depth of the request tracking FIFO (power of 2).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_req_valid  in  1  upstream request valid
- s_req_ready  out  1  upstream request ready
- s_req_paddr  in  ADDR_BITS  start physical address
- s_req_len  in  LEN_BITS  bytes
- s_req_last  in  1  request closes a transfer
- s_req_pid  in  PID_BITS  tag
- m_req_valid  out  1  chunk valid
- m_req_ready  in  1  XDMA ready
- m_req_paddr  out  ADDR_BITS  chunk address
- m_req_len  out  LEN_BITS  chunk bytes
- m_req_last  out  1  s_req_last on final chunk, else 0
- m_req_pid  out  PID_BITS  tag
- s_done_valid  in  1  one pulse per completed chunk (in issue order, no backpressure)
- m_done_valid  out  1  original request complete
- m_done_ready  in  1  done consumer ready
- m_done_pid  out  PID_BITS  tag of completed request

Behaviour:
- Interface: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: all outputs 0, except s_req_ready = 0 during reset and 1 in the first cycle after deassertion. FIFO empty, counters 0, FSM in IDLE.
- FSM IDLE:
  - s_req_ready = 1 when the tracking FIFO is not full.
  - On handshake: latch paddr/len/last/pid; push {pid, n_chunks} to the tracking FIFO; go to ISSUE.
- n_chunks:
  - Computed as ((paddr mod C) + len + C - 1) >> CHUNK_LOG, with C = 2^CHUNK_LOG, evaluated at LEN_BITS+1 width.
  - len = 0 forces n_chunks = 1.
- FSM ISSUE:
  - m_req_valid = 1.
  - m_req_len = min(remaining, C - (addr mod C)).
  - Outputs are registered and held stable until m_req_ready.
  - On handshake: addr += chunk_len, remaining -= chunk_len. If remaining becomes 0 (or len was 0), go to IDLE; else present the next chunk in the following cycle (1 chunk per cycle max).
- Latency: first chunk is valid 1 cycle after s_req handshake. No new request is accepted while in ISSUE.
- Completion tracking:
  - done_cnt increments on each s_done_valid.
  - When done_cnt == head.n_chunks: assert m_done_valid with head.pid. On m_done_ready handshake, pop the head and reset done_cnt to 0.
  - s_done_valid arriving while m_done_valid is stalled is counted toward the next entry; a separate pending counter absorbs the overflow. Chunk completions are never lost.
- Simultaneous push (accept) and pop (done handshake) in the same cycle: both take effect and the occupancy count is unchanged.
- FIFO full: s_req_ready = 0; ISSUE of the current request continues.
- s_done_valid with the FIFO empty is a protocol error: ignored, and an assertion fires in simulation.
- Reset mid-operation: all state is cleared immediately; in-flight chunks are forgotten.

Optional Feature:
- Macro: HDMA_CHUNK_STATS_EN.
- With the macro defined: adds outputs stat_chunks (32b, +1 per m_req handshake) and stat_reqs (32b, +1 per m_done handshake). Both wrap at 2^32 and reset to 0.
- Without the macro: ports and counters are absent.

Decomposition:
- Add to lynxTypes:
  - hdma_chunk_req_t {paddr, len, last, pid}
  - hdma_trk_t {pid, n_chunks[LEN_BITS-CHUNK_LOG+1]}
  - constant HDMA_CHUNK_LOG
- One sub-module: hdma_trk_fifo, a synchronous FIFO (N_OUTSTANDING x hdma_trk_t) with full/empty and simultaneous push/pop.

Test Plan:
- paddr 0x1000, len 0x3000, m_req_ready = 1 -> 3 chunks: 0x1000/0x1000, 0x2000/0x1000, 0x3000/0x1000; last only on third; 3 done pulses -> one m_done with matching pid.
- paddr 0x0F00, len 0x200 -> chunks 0x0F00/0x100 and 0x1000/0x100; n_chunks = 2.
- len 0, pid 5 -> single chunk len 0; one done pulse -> m_done pid 5.
- 16 requests issued, no dones -> s_req_ready = 0 after the 16th acceptance; first done completion with m_done handshake -> ready returns the next cycle.
- m_done_ready held 0 for 10 cycles while dones for the next request arrive -> both m_done emitted in order, no counts lost.
- Assert aresetn mid-ISSUE -> m_req_valid = 0 immediately; after release, a new request is chunked correctly.

Source files
------------

// File: rtl/host_dma_chunker_pkg.sv
// Shared types and default widths for the host DMA chunker and its tracking FIFO.
package host_dma_chunker_pkg;

  localparam int unsigned HDMA_ADDR_BITS = 64;
  localparam int unsigned HDMA_LEN_BITS  = 28;
  localparam int unsigned HDMA_CHUNK_LOG = 12;
  localparam int unsigned HDMA_PID_BITS  = 6;
  localparam int unsigned HDMA_NCH_BITS  = HDMA_LEN_BITS - HDMA_CHUNK_LOG + 1;

  typedef struct packed {
    logic [HDMA_ADDR_BITS-1:0] paddr;
    logic [HDMA_LEN_BITS-1:0]  len;
    logic                      last;
    logic [HDMA_PID_BITS-1:0]  pid;
  } hdma_chunk_req_t;

  typedef struct packed {
    logic [HDMA_PID_BITS-1:0] pid;
    logic [HDMA_NCH_BITS-1:0] n_chunks;
  } hdma_trk_t;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } hdma_chunk_st_e;

endpackage

// File: rtl/hdma_trk_fifo.sv
// Synchronous FIFO holding {pid, n_chunks} for each accepted request; push and pop may coincide.
module hdma_trk_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 23
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW + 1)'(1);
    if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/host_dma_chunker.sv
// Splits host DMA requests into boundary-aligned chunks and emits one in-order done per request.
// Optional HDMA_CHUNK_STATS_EN adds stat_chunks/stat_reqs counters.
module host_dma_chunker
  import host_dma_chunker_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = HDMA_ADDR_BITS,
  parameter int unsigned LEN_BITS      = HDMA_LEN_BITS,
  parameter int unsigned CHUNK_LOG     = HDMA_CHUNK_LOG,
  parameter int unsigned PID_BITS      = HDMA_PID_BITS,
  parameter int unsigned N_OUTSTANDING = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_req_valid,
  output logic                 s_req_ready,
  input  logic [ADDR_BITS-1:0] s_req_paddr,
  input  logic [LEN_BITS-1:0]  s_req_len,
  input  logic                 s_req_last,
  input  logic [PID_BITS-1:0]  s_req_pid,
  output logic                 m_req_valid,
  input  logic                 m_req_ready,
  output logic [ADDR_BITS-1:0] m_req_paddr,
  output logic [LEN_BITS-1:0]  m_req_len,
  output logic                 m_req_last,
  output logic [PID_BITS-1:0]  m_req_pid,
  input  logic                 s_done_valid,
  output logic                 m_done_valid,
  input  logic                 m_done_ready,
  output logic [PID_BITS-1:0]  m_done_pid
`ifdef HDMA_CHUNK_STATS_EN
  ,
  output logic [31:0]          stat_chunks,
  output logic [31:0]          stat_reqs
`endif
);

  localparam int unsigned C  = 1 << CHUNK_LOG;
  localparam int unsigned NW = LEN_BITS - CHUNK_LOG + 1;
  localparam int unsigned TW = PID_BITS + NW;
  localparam int unsigned CW = NW + $clog2(N_OUTSTANDING);

  function automatic logic [LEN_BITS-1:0] room_of(input logic [CHUNK_LOG-1:0] off);
    return LEN_BITS'(C) - LEN_BITS'(off);
  endfunction

  function automatic logic [LEN_BITS-1:0] chunk_len(input logic [CHUNK_LOG-1:0] off,
                                                   input logic [LEN_BITS-1:0]  rem);
    return (rem < room_of(off)) ? rem : room_of(off);
  endfunction

  hdma_chunk_st_e       state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, nxt_addr;
  logic [LEN_BITS-1:0]  rem_q, rem_d, nxt_rem;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic                 fin_q, fin_d, last_q, last_d, rdy_q;
  logic [PID_BITS-1:0]  pid_q, pid_d;
  logic [CW-1:0]        done_cnt_q, done_cnt_d;

  logic [LEN_BITS:0]    nsum;
  logic [NW-1:0]        n_chunks, head_n;
  logic [PID_BITS-1:0]  head_pid;
  logic [TW-1:0]        trk_rdata;
  logic                 trk_push, trk_pop, trk_full, trk_empty, done_inc;

  // rdy_q holds s_req_ready low while in reset and for the edge that releases it.
  assign s_req_ready = rdy_q && (state_q == StIdle) && !trk_full;
  assign m_req_valid = (state_q == StIssue);
  assign m_req_paddr = addr_q;
  assign m_req_len   = len_q;
  assign m_req_last  = last_q && fin_q;
  assign m_req_pid   = pid_q;

  assign nxt_addr = addr_q + ADDR_BITS'(len_q);
  assign nxt_rem  = rem_q - len_q;

  assign nsum     = (LEN_BITS + 1)'(s_req_paddr[CHUNK_LOG-1:0]) + (LEN_BITS + 1)'(s_req_len)
                  + (LEN_BITS + 1)'(C - 1);
  assign n_chunks = (s_req_len == '0) ? NW'(1) : NW'(nsum >> CHUNK_LOG);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    len_d    = len_q;
    fin_d    = fin_q;
    last_d   = last_q;
    pid_d    = pid_q;
    trk_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_req_valid && s_req_ready) begin
          addr_d   = s_req_paddr;
          rem_d    = s_req_len;
          len_d    = chunk_len(s_req_paddr[CHUNK_LOG-1:0], s_req_len);
          fin_d    = (s_req_len <= room_of(s_req_paddr[CHUNK_LOG-1:0]));
          last_d   = s_req_last;
          pid_d    = s_req_pid;
          trk_push = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (m_req_ready) begin
          if (fin_q) begin
            state_d = StIdle;
          end else begin
            addr_d = nxt_addr;
            rem_d  = nxt_rem;
            len_d  = chunk_len(nxt_addr[CHUNK_LOG-1:0], nxt_rem);
            fin_d  = (nxt_rem <= room_of(nxt_addr[CHUNK_LOG-1:0]));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      fin_q   <= 1'b0;
      last_q  <= 1'b0;
      pid_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
      last_q  <= last_d;
      pid_q   <= pid_d;
      rdy_q   <= 1'b1;
    end
  end

  hdma_trk_fifo #(
    .Depth (N_OUTSTANDING),
    .Width (TW)
  ) u_trk_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .push_i  (trk_push),
    .wdata_i ({s_req_pid, n_chunks}),
    .pop_i   (trk_pop),
    .rdata_o (trk_rdata),
    .full_o  (trk_full),
    .empty_o (trk_empty)
  );

  assign head_n   = trk_rdata[NW-1:0];
  assign head_pid = trk_rdata[TW-1:NW];

  // Completions beyond the head's count stay in done_cnt and roll over to the next entry on pop.
  assign done_inc     = s_done_valid && !trk_empty;
  assign m_done_valid = !trk_empty && (done_cnt_q >= CW'(head_n));
  assign m_done_pid   = m_done_valid ? head_pid : '0;
  assign trk_pop      = m_done_valid && m_done_ready;

  always_comb begin
    done_cnt_d = done_cnt_q + CW'(done_inc);
    if (trk_pop) done_cnt_d = done_cnt_d - CW'(head_n);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) done_cnt_q <= '0;
    else          done_cnt_q <= done_cnt_d;
  end

`ifdef HDMA_CHUNK_STATS_EN
  logic [31:0] stat_chunks_q, stat_reqs_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_chunks_q <= '0;
      stat_reqs_q   <= '0;
    end else begin
      if (m_req_valid && m_req_ready) stat_chunks_q <= stat_chunks_q + 32'd1;
      if (trk_pop)                    stat_reqs_q   <= stat_reqs_q + 32'd1;
    end
  end

  assign stat_chunks = stat_chunks_q;
  assign stat_reqs   = stat_reqs_q;
`endif

`ifndef SYNTHESIS
  a_done_on_empty: assert property (@(posedge aclk) disable iff (!aresetn)
                                    !(s_done_valid && trk_empty))
    else $error("host_dma_chunker: s_done_valid with no tracked request");
`endif

endmodule

// File: tb/tb_host_dma_chunker.sv
// Directed bench for host_dma_chunker: chunking, done tracking, FIFO full, done stall, reset.
module tb_host_dma_chunker;

  logic        aclk;
  logic        aresetn;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [63:0] s_req_paddr;
  logic [27:0] s_req_len;
  logic        s_req_last;
  logic [5:0]  s_req_pid;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [63:0] m_req_paddr;
  logic [27:0] m_req_len;
  logic        m_req_last;
  logic [5:0]  m_req_pid;
  logic        s_done_valid;
  logic        m_done_valid;
  logic        m_done_ready;
  logic [5:0]  m_done_pid;

  int n_chk  = 0;
  int n_pass = 0;

  host_dma_chunker dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_paddr  (s_req_paddr),
    .s_req_len    (s_req_len),
    .s_req_last   (s_req_last),
    .s_req_pid    (s_req_pid),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_paddr  (m_req_paddr),
    .m_req_len    (m_req_len),
    .m_req_last   (m_req_last),
    .m_req_pid    (m_req_pid),
    .s_done_valid (s_done_valid),
    .m_done_valid (m_done_valid),
    .m_done_ready (m_done_ready),
    .m_done_pid   (m_done_pid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_chunk(input string tag, input logic [63:0] addr, input logic [27:0] len,
                           input logic last, input logic [5:0] pid);
    chk({tag, "_valid"}, 64'(m_req_valid), 64'd1);
    chk({tag, "_addr"},  m_req_paddr,      addr);
    chk({tag, "_len"},   64'(m_req_len),   64'(len));
    chk({tag, "_last"},  64'(m_req_last),  64'(last));
    chk({tag, "_pid"},   64'(m_req_pid),   64'(pid));
  endtask

  // Waits (bounded) for s_req_ready, then performs one request handshake.
  task automatic send_req(input logic [63:0] addr, input logic [27:0] len, input logic last,
                          input logic [5:0] pid);
    for (int k = 0; k < 50 && !s_req_ready; k++) tick();
    chk("req_ready", 64'(s_req_ready), 64'd1);
    s_req_valid = 1'b1;
    s_req_paddr = addr;
    s_req_len   = len;
    s_req_last  = last;
    s_req_pid   = pid;
    tick();
    s_req_valid = 1'b0;
  endtask

  task automatic drain_chunks();
    for (int k = 0; k < 64 && m_req_valid; k++) tick();
    chk("chunks_drained", 64'(m_req_valid), 64'd0);
  endtask

  task automatic pulse_done(input int n);
    s_done_valid = 1'b1;
    for (int k = 0; k < n; k++) tick();
    s_done_valid = 1'b0;
  endtask

  initial begin
    aresetn      = 1'b0;
    s_req_valid  = 1'b0;
    s_req_paddr  = '0;
    s_req_len    = '0;
    s_req_last   = 1'b0;
    s_req_pid    = '0;
    m_req_ready  = 1'b1;
    s_done_valid = 1'b0;
    m_done_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_req_ready",  64'(s_req_ready),  64'd0);
    chk("rst_m_req_valid",  64'(m_req_valid),  64'd0);
    chk("rst_m_req_paddr",  m_req_paddr,       64'd0);
    chk("rst_m_req_len",    64'(m_req_len),    64'd0);
    chk("rst_m_done_valid", 64'(m_done_valid), 64'd0);
    chk("rst_m_done_pid",   64'(m_done_pid),   64'd0);
    #2 aresetn = 1'b1;
    tick();
    chk("post_rst_ready", 64'(s_req_ready), 64'd1);

    // Aligned 3-chunk request
    send_req(64'h1000, 28'h3000, 1'b1, 6'd3);
    chk("t1_ready_in_issue", 64'(s_req_ready), 64'd0);
    chk_chunk("t1_c0", 64'h1000, 28'h1000, 1'b0, 6'd3);
    tick();
    chk_chunk("t1_c1", 64'h2000, 28'h1000, 1'b0, 6'd3);
    tick();
    chk_chunk("t1_c2", 64'h3000, 28'h1000, 1'b1, 6'd3);
    tick();
    chk("t1_idle_valid", 64'(m_req_valid), 64'd0);
    chk("t1_idle_ready", 64'(s_req_ready), 64'd1);
    pulse_done(2);
    chk("t1_done_early", 64'(m_done_valid), 64'd0);
    pulse_done(1);
    chk("t1_done_valid", 64'(m_done_valid), 64'd1);
    chk("t1_done_pid",   64'(m_done_pid),   64'd3);
    tick();
    chk("t1_done_popped", 64'(m_done_valid), 64'd0);

    // Request straddling a 4 KB boundary
    send_req(64'h0F00, 28'h200, 1'b1, 6'd7);
    chk_chunk("t2_c0", 64'h0F00, 28'h100, 1'b0, 6'd7);
    tick();
    chk_chunk("t2_c1", 64'h1000, 28'h100, 1'b1, 6'd7);
    tick();
    chk("t2_idle_valid", 64'(m_req_valid), 64'd0);
    pulse_done(1);
    chk("t2_done_early", 64'(m_done_valid), 64'd0);
    pulse_done(1);
    chk("t2_done_valid", 64'(m_done_valid), 64'd1);
    chk("t2_done_pid",   64'(m_done_pid),   64'd7);
    tick();
    chk("t2_done_popped", 64'(m_done_valid), 64'd0);

    // Zero-length request
    send_req(64'h2345, 28'h0, 1'b1, 6'd5);
    chk_chunk("t3_c0", 64'h2345, 28'h0, 1'b1, 6'd5);
    tick();
    chk("t3_idle_valid", 64'(m_req_valid), 64'd0);
    pulse_done(1);
    chk("t3_done_valid", 64'(m_done_valid), 64'd1);
    chk("t3_done_pid",   64'(m_done_pid),   64'd5);
    tick();
    chk("t3_done_popped", 64'(m_done_valid), 64'd0);

    // Fill the tracking FIFO with 16 single-chunk requests
    for (int i = 0; i < 16; i++) begin
      send_req(64'(i) << 12, 28'h40, 1'b0, 6'(i));
      drain_chunks();
      if (i == 14) chk("t4_ready_at_15", 64'(s_req_ready), 64'd1);
    end
    chk("t4_full_ready", 64'(s_req_ready), 64'd0);
    tick();
    chk("t4_full_hold", 64'(s_req_ready), 64'd0);
    pulse_done(1);
    chk("t4_head_valid", 64'(m_done_valid), 64'd1);
    chk("t4_head_pid",   64'(m_done_pid),   64'd0);
    chk("t4_still_full", 64'(s_req_ready),  64'd0);
    tick();
    chk("t4_ready_back", 64'(s_req_ready), 64'd1);
    for (int i = 1; i < 16; i++) begin
      pulse_done(1);
      chk("t4_drain_valid", 64'(m_done_valid), 64'd1);
      chk("t4_drain_pid",   64'(m_done_pid),   64'(i));
    end
    tick();
    chk("t4_empty", 64'(m_done_valid), 64'd0);

    // Done consumer stalled while the next request's completion arrives
    send_req(64'h0, 28'h2000, 1'b1, 6'd10);
    drain_chunks();
    send_req(64'h5000, 28'h1000, 1'b1, 6'd11);
    drain_chunks();
    m_done_ready = 1'b0;
    pulse_done(2);
    chk("t5_a_valid", 64'(m_done_valid), 64'd1);
    chk("t5_a_pid",   64'(m_done_pid),   64'd10);
    for (int k = 0; k < 10; k++) begin
      s_done_valid = (k == 3);
      tick();
    end
    s_done_valid = 1'b0;
    chk("t5_a_stalled_valid", 64'(m_done_valid), 64'd1);
    chk("t5_a_stalled_pid",   64'(m_done_pid),   64'd10);
    m_done_ready = 1'b1;
    tick();
    chk("t5_b_valid", 64'(m_done_valid), 64'd1);
    chk("t5_b_pid",   64'(m_done_pid),   64'd11);
    tick();
    chk("t5_empty", 64'(m_done_valid), 64'd0);

    // Reset while a request is being chunked
    m_req_ready = 1'b0;
    send_req(64'h7000, 28'h3000, 1'b1, 6'd20);
    chk("t6_issuing", 64'(m_req_valid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_m_req_valid", 64'(m_req_valid),  64'd0);
    chk("t6_rst_s_req_ready", 64'(s_req_ready),  64'd0);
    chk("t6_rst_done_valid",  64'(m_done_valid), 64'd0);
    #2 aresetn = 1'b1;
    m_req_ready = 1'b1;
    tick();
    send_req(64'h1800, 28'h1000, 1'b1, 6'd21);
    chk_chunk("t6_c0", 64'h1800, 28'h800, 1'b0, 6'd21);
    tick();
    chk_chunk("t6_c1", 64'h2000, 28'h800, 1'b1, 6'd21);
    tick();
    chk("t6_idle_valid", 64'(m_req_valid), 64'd0);
    pulse_done(2);
    chk("t6_done_valid", 64'(m_done_valid), 64'd1);
    chk("t6_done_pid",   64'(m_done_pid),   64'd21);
    tick();
    chk("t6_done_popped", 64'(m_done_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
